// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES decryptor.
//   NR_DEFAULT       default number of AES rounds (10 = AES-128)
//   fsm_t            controller states IDLE / ROUND / DONE
//   xtime, mul9/B/D/E GF(2^8) multiply helpers (AES polynomial 0x11b)
//   inv_sbox         inverse S-box, derived as GF inverse of the inverse affine map
//   inv_shift_src / inv_shift_rows   InvShiftRows byte permutation
//   inv_mix_column   InvMixColumns on one 32-bit column
// Byte i of a 128-bit block sits at [127-8*i -: 8]; byte i is row i%4, column i/4.
package aes_dec_pkg;

    localparam int NR_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        logic [7:0] b8;
        b8 = xtime(xtime(xtime(b)));
        return b8 ^ b;
    endfunction

    function automatic logic [7:0] mulB(input logic [7:0] b);
        logic [7:0] b2, b8;
        b2 = xtime(b);
        b8 = xtime(xtime(b2));
        return b8 ^ b2 ^ b;
    endfunction

    function automatic logic [7:0] mulD(input logic [7:0] b);
        logic [7:0] b4, b8;
        b4 = xtime(xtime(b));
        b8 = xtime(b4);
        return b8 ^ b4 ^ b;
    endfunction

    function automatic logic [7:0] mulE(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b4 ^ b2;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8), and 0 maps to 0 as AES requires.
    // 254 = 0b1111_1110, so every squared power except a^1 is multiplied in.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    // Undo the S-box affine map (rotl 1/3/6 ^ 0x05), then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] x;
        x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(x);
    endfunction

    // Row r rotates right by r: output byte (row r, col c) comes from col (c-r) mod 4.
    function automatic int inv_shift_src(input int idx);
        int r, c;
        r = idx % 4;
        c = idx / 4;
        return 4 * ((c - r + 4) % 4) + r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = s[127-8*inv_shift_src(i) -: 8];
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {mulE(a0) ^ mulB(a1) ^ mulD(a2) ^ mul9(a3),
                mul9(a0) ^ mulE(a1) ^ mulB(a2) ^ mulD(a3),
                mulD(a0) ^ mul9(a1) ^ mulE(a2) ^ mulB(a3),
                mulB(a0) ^ mulD(a1) ^ mul9(a2) ^ mulE(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse-cipher round, purely combinational.
//   state_in        128-bit state entering the round
//   round_key       128-bit key XORed after InvSubBytes
//   sel_inv_mix_col 1 = apply InvMixColumns after AddRoundKey (all but the last round)
//   state_out       128-bit state leaving the round
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         sel_inv_mix_col,
    output logic [127:0] state_out
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    assign shifted = inv_shift_rows(state_in);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub
            assign subbed[127-8*gi -: 8] = inv_sbox(shifted[127-8*gi -: 8]);
        end
    endgenerate

    assign keyed = subbed ^ round_key;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign mixed[127-32*gi -: 32] = inv_mix_column(keyed[127-32*gi -: 32]);
        end
    endgenerate

    assign state_out = sel_inv_mix_col ? mixed : keyed;

endmodule

// File: rtl/aes_iterative_decrypt.sv
// Folded AES inverse cipher: one inverse round per clock through a single
// aes_inv_round instance, ready/valid handshake on input and output.
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready/ciphertext            block input; in_ready == (fsm == IDLE)
//   round_keys_flat  (NR+1) encryption round keys, key k at [k*128 +: 128]
//   out_valid/out_ready/plaintext           block output, held until accepted
// Optional macro AES_DEC_KEY_LATCH_EN: capture round_keys_flat on the accept
// edge so the key bus may change while a block is in flight.
module aes_iterative_decrypt
    import aes_dec_pkg::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          ciphertext,
    input  logic [(NR+1)*128-1:0] round_keys_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          plaintext
);

    localparam int RCNT_W = $clog2(NR);

    fsm_t                  fsm_reg, fsm_next;
    logic [127:0]          state_reg, state_next;
    logic [RCNT_W-1:0]     rcnt_reg, rcnt_next;
    logic [(NR+1)*128-1:0] keys_used;
    logic [127:0]          key_arr [0:NR];
    logic [127:0]          round_key;
    logic                  sel_inv_mix_col;
    logic [127:0]          round_out;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [(NR+1)*128-1:0] key_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg <= '0;
        end else if (in_ready && in_valid) begin
            key_reg <= round_keys_flat;
        end
    end

    assign keys_used = key_reg;
`else
    assign keys_used = round_keys_flat;
`endif

    genvar gi;
    generate
        for (gi = 0; gi <= NR; gi++) begin : g_key
            assign key_arr[gi] = keys_used[gi*128 +: 128];
        end
    endgenerate

    // rcnt counts down NR-1 .. 0 and stops, so it always indexes a valid key.
    assign round_key       = key_arr[rcnt_reg];
    assign sel_inv_mix_col = (rcnt_reg != '0);

    aes_inv_round u_round (
        .state_in        (state_reg),
        .round_key       (round_key),
        .sel_inv_mix_col (sel_inv_mix_col),
        .state_out       (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            rcnt_reg  <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
            rcnt_reg  <= rcnt_next;
        end
    end

    always_comb begin
        fsm_next   = fsm_reg;
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        case (fsm_reg)
            IDLE: begin
                // The initial AddRoundKey always comes straight off the bus:
                // the optional key register is only loaded on this same edge.
                if (in_valid) begin
                    state_next = ciphertext ^ round_keys_flat[NR*128 +: 128];
                    rcnt_next  = RCNT_W'(NR - 1);
                    fsm_next   = ROUND;
                end
            end
            ROUND: begin
                state_next = round_out;
                if (rcnt_reg != '0) begin
                    rcnt_next = rcnt_reg - 1'b1;
                end else begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (fsm_reg == IDLE);
    assign out_valid = (fsm_reg == DONE);
    assign plaintext = state_reg;

endmodule
